// File: rtl/rgmii_tx_clk_sequencer.sv
// Forwarded-clock pattern sequencer for the RGMII transmit side.
// Emits 2-bit clock pairs for 125/25/2.5 MHz; starts, stops and changes speed only on period boundaries.
module rgmii_tx_clk_sequencer #(
    parameter logic [1:0] DEFAULT_SPEED = 2'b10
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic [1:0] speed_i,
    input  logic       ready_i,
    output logic [1:0] clk_setting_o,
    output logic [1:0] speed_o,
    output logic       running_o,
    output logic       rise_o
);

    localparam int unsigned POS_W   = 6;
    localparam int unsigned SPD_W   = 2;
    localparam int unsigned BIT_W   = POS_W + 1;

    localparam logic [SPD_W-1:0] SPD_10M  = 2'b00;
    localparam logic [SPD_W-1:0] SPD_100M = 2'b01;
    localparam logic [SPD_W-1:0] SPD_RSVD = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [POS_W-1:0]   pos_q,   pos_d;
    logic [SPD_W-1:0]   speed_q, speed_d;

    logic [POS_W-1:0]   period;
    logic               at_boundary;
    logic               speed_change;
    logic [BIT_W-1:0]   bit_idx0;
    logic [BIT_W-1:0]   bit_idx1;
    logic [1:0]         pattern;

    // Period in pairs; numerically equal to the half-period in cycles.
    always_comb begin
        period = POS_W'(1);
        case (speed_q)
            SPD_10M:  period = POS_W'(50);
            SPD_100M: period = POS_W'(5);
            default:  period = POS_W'(1);
        endcase
    end

    // Clock is high for the first H bits of the 2H-bit period.
    always_comb begin
        bit_idx0 = {pos_q, 1'b0};
        bit_idx1 = {pos_q, 1'b1};
        pattern  = {(bit_idx1 < BIT_W'(period)), (bit_idx0 < BIT_W'(period))};
    end

    assign at_boundary  = (pos_q == (period - POS_W'(1)));
    assign speed_change = (speed_i != SPD_RSVD) && (speed_i != speed_q);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            speed_q <= DEFAULT_SPEED;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            speed_q <= speed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        speed_d = speed_q;
        case (state_q)
            ST_IDLE: begin
                if (speed_change) begin
                    speed_d = speed_i;
                end
                if (enable_i && ready_i) begin
                    state_d = ST_RUN;
                    pos_d   = '0;
                end
            end
            ST_RUN: begin
                if (ready_i) begin
                    if (at_boundary) begin
                        pos_d = '0;
                        if (!enable_i) begin
                            state_d = ST_IDLE;
                        end
                        if (speed_change) begin
                            speed_d = speed_i;
                        end
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pos_d   = '0;
            end
        endcase
    end

    // Output is forced low while in reset so a mid-period reset cuts the clock at once.
    always_comb begin
        clk_setting_o = 2'b00;
        if (!reset_i && (state_q == ST_RUN)) begin
            clk_setting_o = pattern;
        end
    end

    assign speed_o   = speed_q;
    assign running_o = (state_q == ST_RUN);
    assign rise_o    = (state_q == ST_RUN) && ready_i && (pos_q == '0);

endmodule

// File: tb/tb_rgmii_tx_clk_sequencer.sv
// Randomized bench for rgmii_tx_clk_sequencer against a waveform-queue reference model.
module tb_rgmii_tx_clk_sequencer;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       enable_i;
    logic [1:0] speed_i;
    logic       ready_i;
    logic [1:0] clk_setting_o;
    logic [1:0] speed_o;
    logic       running_o;
    logic       rise_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    localparam int DEF_SPEED = 2;

    rgmii_tx_clk_sequencer #(.DEFAULT_SPEED(2'b10)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .speed_i       (speed_i),
        .ready_i       (ready_i),
        .clk_setting_o (clk_setting_o),
        .speed_o       (speed_o),
        .running_o     (running_o),
        .rise_o        (rise_o)
    );

    always #2 clk_i = ~clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Reference model: one forwarded-clock period is queued as pairs when it begins.
    bit          m_run   = 1'b0;
    int          m_speed = DEF_SPEED;
    logic [1:0]  m_q[$];

    function automatic int half_period(input int spd);
        case (spd)
            0:       return 50;
            1:       return 5;
            default: return 1;
        endcase
    endfunction

    task automatic fill_period(input int spd);
        int h;
        bit wave[$];
        h = half_period(spd);
        wave = {};
        for (int i = 0; i < h; i++) wave.push_back(1'b1);
        for (int i = 0; i < h; i++) wave.push_back(1'b0);
        m_q = {};
        for (int k = 0; k < h; k++) m_q.push_back({wave[2*k+1], wave[2*k]});
    endtask

    function automatic bit valid_change(input int req, input int cur);
        return (req != 3) && (req != cur);
    endfunction

    task automatic model_step();
        if (reset_i) begin
            m_run = 1'b0;
            m_speed = DEF_SPEED;
            m_q = {};
        end else if (!m_run) begin
            if (valid_change(int'(speed_i), m_speed)) m_speed = int'(speed_i);
            if (enable_i && ready_i) begin
                m_run = 1'b1;
                fill_period(m_speed);
            end
        end else if (ready_i) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                if (valid_change(int'(speed_i), m_speed)) m_speed = int'(speed_i);
                if (!enable_i) m_run = 1'b0;
                else fill_period(m_speed);
            end
        end
    endtask

    task automatic check_outputs();
        int exp_set;
        int exp_rise;
        exp_set  = (!reset_i && m_run) ? int'(m_q[0]) : 0;
        exp_rise = (m_run && ready_i && (m_q.size() == half_period(m_speed))) ? 1 : 0;
        check("clk_setting", int'(clk_setting_o), exp_set);
        check("speed", int'(speed_o), m_speed);
        check("running", int'(running_o), int'(m_run));
        check("rise", int'(rise_o), exp_rise);
    endtask

    // Applies inputs after the edge, checks mid-cycle, then advances the model for the coming edge.
    task automatic cycle(input bit rst, input bit en, input logic [1:0] spd, input bit rdy);
        @(posedge clk_i);
        #1;
        reset_i  = rst;
        enable_i = en;
        speed_i  = spd;
        ready_i  = rdy;
        @(negedge clk_i);
        check_outputs();
        model_step();
    endtask

    initial begin
        bit         en;
        bit         rdy;
        logic [1:0] spd;
        reset_i  = 1'b1;
        enable_i = 1'b0;
        speed_i  = 2'b10;
        ready_i  = 1'b0;

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 2'b10, i[0]);

        // Directed warm-up per speed: 1G, 100M, 10M, then a stop.
        rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin rdy = ~rdy; cycle(1'b0, 1'b1, 2'b10, rdy); end
        for (int i = 0; i < 40; i++) begin rdy = ~rdy; cycle(1'b0, 1'b1, 2'b01, rdy); end
        for (int i = 0; i < 250; i++) begin rdy = ~rdy; cycle(1'b0, 1'b1, 2'b00, rdy); end
        for (int i = 0; i < 150; i++) begin rdy = ~rdy; cycle(1'b0, 1'b0, 2'b11, rdy); end

        en  = 1'b1;
        spd = 2'b01;
        for (int i = 0; i < 12000; i++) begin
            rdy = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : ~rdy;
            if ($urandom_range(0, 179) == 0) en = ~en;
            if ($urandom_range(0, 149) == 0) spd = 2'($urandom_range(0, 3));
            cycle(($urandom_range(0, 1999) == 0), en, spd, rdy);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
